lsu_rmw: RTL and testbench

- Load/store initiator sitting between the CPU memory stage and the word-wide data memory (dmem): async read, sync write, no byte enables.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Extracts and sign- or zero-extends sub-word load data.
- Performs read-modify-write for sub-word stores.
- Flags misaligned and reserved-size requests without touching memory.

---
 rtl/lsu_pkg.sv | 74 +++++++
 rtl/lsu_lane.sv | 25 ++
 rtl/lsu_rmw.sv | 135 +++++++++++++
 tb/tb_lsu_rmw.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - size_e  : request size encodings (byte/half/word/reserved)
//   - state_e : lsu_rmw control states
//   - access_err   : flags reserved size or misaligned address
//   - lane_extract : pulls a byte/half lane out of a word and extends it
//   - lane_merge   : overwrites one byte/half lane of a word with store data
package lsu_pkg;

    localparam int LANE_WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [LANE_WORD_W-1:0] lane_extract(
        input logic [LANE_WORD_W-1:0] word,
        input logic [1:0]             size,
        input logic [1:0]             off,
        input logic                   uns
    );
        logic [7:0]             b;
        logic [15:0]            h;
        logic [LANE_WORD_W-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
            SZ_HALF: r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [LANE_WORD_W-1:0] lane_merge(
        input logic [LANE_WORD_W-1:0] word,
        input logic [LANE_WORD_W-1:0] wdata,
        input logic [1:0]             size,
        input logic [1:0]             off
    );
        logic [LANE_WORD_W-1:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic shared by the load and store paths.
// Ports:
//   size_i   - request size (size_e encoding)
//   off_i    - byte offset within the word (addr[1:0])
//   uns_i    - 1 = zero-extend loads, 0 = sign-extend
//   rdata_i  - word read from dmem
//   wdata_i  - store data (value in low bits)
//   ext_o    - extracted and extended load data
//   merged_o - rdata_i with the target lane replaced by wdata_i
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]             size_i,
    input  logic [1:0]             off_i,
    input  logic                   uns_i,
    input  logic [LANE_WORD_W-1:0] rdata_i,
    input  logic [LANE_WORD_W-1:0] wdata_i,
    output logic [LANE_WORD_W-1:0] ext_o,
    output logic [LANE_WORD_W-1:0] merged_o
);

    assign ext_o    = lane_extract(rdata_i, size_i, off_i, uns_i);
    assign merged_o = lane_merge(rdata_i, wdata_i, size_i, off_i);

endmodule

// File: rtl/lsu_rmw.sv
// Load/store initiator between the CPU memory stage and a word-wide dmem
// (async read, sync write, no byte enables). Sub-word stores are done as
// read-modify-write; misaligned or reserved-size requests respond with an
// error and never touch memory.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   req_*            - request channel (valid/ready), captured on transfer
//   resp_valid       - one-cycle completion pulse, with resp_rdata / resp_err
//   mem_we/addr/wdata- dmem write enable, word-aligned address, write data
//   mem_rdata        - dmem async read data
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q, state_d;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic                  err_q;

    logic                  accept;
    logic                  req_err;
    logic                  sub_store;
    logic [DATA_WIDTH-1:0] ext_data;
    logic [DATA_WIDTH-1:0] merged_data;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign req_err   = access_err(req_size, req_addr[1:0]);
    assign sub_store = we_q && (size_q != SZ_WORD);

    lsu_lane u_lane (
        .size_i   (size_q),
        .off_i    (addr_q[1:0]),
        .uns_i    (uns_q),
        .rdata_i  (mem_rdata),
        .wdata_i  (wdata_q),
        .ext_o    (ext_data),
        .merged_o (merged_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = req_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_d = sub_store ? ST_WRITE : ST_RESP;
            ST_WRITE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; mem_we drops as soon as reset forces IDLE.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = wdata_q;
        case (state_q)
            ST_IDLE:   req_ready = 1'b1;
            ST_ACCESS: mem_we = we_q && (size_q == SZ_WORD);
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = merged_q;
            end
            ST_RESP:   resp_valid = 1'b1;
            default:   ;
        endcase
    end

    assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Capture and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                // Stores and errors report zero data; loads overwrite in ACCESS.
                rdata_q <= '0;
            end
            if (state_q == ST_ACCESS) begin
                if (!we_q) rdata_q <= ext_data;
                merged_q <= merged_data;
            end
            if (state_q == ST_RESP) err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_err, mem_we;
    logic [DW-1:0] resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    lsu_rmw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench dmem: async read, sync write; backdoor port used only for preload.
    logic [31:0] dmem    [0:63];
    logic [31:0] ref_mem [0:63];
    logic        bk_we = 1'b0;
    logic [5:0]  bk_idx = '0;
    logic [31:0] bk_data = '0;
    assign mem_rdata = dmem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we)     dmem[mem_addr[7:2]] <= mem_wdata;
        else if (bk_we) dmem[bk_idx] <= bk_data;
    end

    int checks = 0;
    int errors = 0;

    typedef struct { int due; logic err; logic [31:0] rdata; } resp_t;
    typedef struct { int due; logic [7:0] addr; logic [31:0] data; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: plain shift/mask arithmetic on whole words.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int size,
                                               input int off, input logic uns);
        logic [31:0] v;
        if (size == 0) begin
            v = (word >> (off * 8)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (size == 1) begin
            v = (word >> ((off / 2) * 16)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] wd,
                                                input int size, input int off);
        logic [31:0] mask;
        int          sh;
        if (size == 0)      begin mask = 32'hFF;   sh = off * 8; end
        else if (size == 1) begin mask = 32'hFFFF; sh = (off / 2) * 16; end
        else                begin mask = 32'hFFFFFFFF; sh = 0; end
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wd, output int t_acc);
        int          n;
        int          sz, off;
        logic        err;
        logic [31:0] word, nw;
        resp_t       r;
        wr_t         w;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1");
            t_acc = -1;
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = {8'h00, addr}; req_wdata = wd;
        t_acc = cyc;
        sz  = int'(size);
        off = int'(addr[1:0]);
        err = (sz == 3) || (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
        word = ref_mem[addr[7:2]];
        if (err) begin
            r = '{cyc + 1, 1'b1, 32'h0};
        end else if (!we) begin
            r = '{cyc + 2, 1'b0, model_load(word, sz, off, uns)};
        end else begin
            nw = model_store(word, wd, sz, off);
            ref_mem[addr[7:2]] = nw;
            w = '{(sz == 2) ? cyc + 1 : cyc + 2, {addr[7:2], 2'b00}, nw};
            wq.push_back(w);
            r = '{(sz == 2) ? cyc + 2 : cyc + 3, 1'b0, 32'h0};
        end
        rq.push_back(r);
        $display("REQ  cyc=%0d we=%0b size=%0d uns=%0b addr=%02h wdata=%08h", cyc, we, sz, uns, addr, wd);
        @(posedge clk);
        #1;
        // Scramble inputs while busy; the captured copies must be used.
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = 16'($urandom); req_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (rq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d resp / %0d writes pending expected 0", rq.size(), wq.size());
            rq.delete(); wq.delete();
        end
        @(negedge clk);
    endtask

    // Response monitor
    always @(negedge clk) begin : mon_resp
        resp_t r;
        if (!rst) begin
            if (resp_valid) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got resp at cyc %0d expected none", cyc);
                end else begin
                    r = rq.pop_front();
                    if (r.due != cyc || resp_err !== r.err || resp_rdata !== r.rdata) begin
                        errors++;
                        $display("FAIL resp: got cyc=%0d err=%0b rdata=%08h expected cyc=%0d err=%0b rdata=%08h",
                                 cyc, resp_err, resp_rdata, r.due, r.err, r.rdata);
                    end else begin
                        $display("RESP cyc=%0d err=%0b rdata=%08h", cyc, resp_err, resp_rdata);
                    end
                    last_rdata = resp_rdata;
                    last_err   = resp_err;
                end
            end else if (rq.size() != 0 && rq[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL resp_missing: got none by cyc %0d expected at cyc %0d", cyc, rq[0].due);
                void'(rq.pop_front());
            end
        end
    end

    // Memory write monitor
    always @(negedge clk) begin : mon_wr
        wr_t w;
        if (!rst) begin
            if (mem_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got mem_we at cyc %0d addr=%04h expected none", cyc, mem_addr);
                end else begin
                    w = wq.pop_front();
                    if (w.due != cyc || mem_addr !== {8'h00, w.addr} || mem_wdata !== w.data) begin
                        errors++;
                        $display("FAIL write: got cyc=%0d addr=%04h data=%08h expected cyc=%0d addr=%02h data=%08h",
                                 cyc, mem_addr, mem_wdata, w.due, w.addr, w.data);
                    end
                end
            end else if (wq.size() != 0 && wq[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL write_missing: got none by cyc %0d expected at cyc %0d", cyc, wq[0].due);
                void'(wq.pop_front());
            end
        end
    end

    initial begin
        int          t1, t2;
        logic [31:0] old_word;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Preload memory (backdoor, held in reset).
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bk_we = 1'b1; bk_idx = 6'(i);
            bk_data = (i == 4) ? 32'h8899AABB : $urandom;
            ref_mem[i] = bk_data;
        end
        @(negedge clk);
        bk_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);

        // Directed loads on word 0x10 = 0x8899AABB
        issue(1'b0, 2'b00, 1'b0, 8'h12, 32'h0, t1); drain();
        chk("lb_signed", last_rdata, 32'hFFFFFF99);
        issue(1'b0, 2'b00, 1'b1, 8'h12, 32'h0, t1); drain();
        chk("lbu", last_rdata, 32'h00000099);
        issue(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, t1); drain();
        chk("lh_signed", last_rdata, 32'hFFFF8899);
        issue(1'b0, 2'b01, 1'b0, 8'h13, 32'h0, t1); drain();
        chk("lh_misaligned_err", 32'(last_err), 32'd1);

        // Byte store with RMW, then readback
        issue(1'b1, 2'b00, 1'b0, 8'h11, 32'h0000005A, t1); drain();
        issue(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, t1); drain();
        chk("sb_readback", last_rdata, 32'h88995ABB);

        // Word store then back-to-back load
        issue(1'b1, 2'b10, 1'b0, 8'h20, 32'hDEADBEEF, t1);
        issue(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, t2);
        chk("b2b_accept_gap", 32'(t2 - t1), 32'd3);
        drain();
        chk("sw_readback", last_rdata, 32'hDEADBEEF);

        // Reserved size
        issue(1'b1, 2'b11, 1'b0, 8'h24, 32'h12345678, t1); drain();
        chk("rsvd_err", 32'(last_err), 32'd1);
        chk("rsvd_rdata", last_rdata, 32'h0);

        // Reset during the WRITE cycle of a byte store
        old_word = ref_mem[5];
        issue(1'b1, 2'b00, 1'b0, 8'h15, 32'h00000077, t1);
        while (cyc < t1 + 2) @(negedge clk);
        chk("rmw_we_in_write", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_mem_we", 32'(mem_we), 32'd0);
        rq.delete(); wq.delete();
        ref_mem[5] = old_word;
        @(negedge clk);
        chk("rst_mem_unchanged", dmem[5], old_word);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        chk("rst_release_resp_valid", 32'(resp_valid), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 8'h14, 32'h0, t1); drain();
        chk("rst_readback", last_rdata, old_word);

        // Randomized traffic over a small address range to force reuse
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 63)), $urandom, t1);
        end
        drain();
        for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
